// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues in-order imem reads and buffers FIFO_DEPTH {pc, instr} slots for ID.
// Define IF_PERF_CNT_EN to add the perf_fetch_cnt / perf_stall_cnt outputs.
module if_fetch_unit #(
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       DATA_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter logic [ADDR_W-1:0] PC_INC     = ADDR_W'(4),
    parameter int unsigned       FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [DATA_W-1:0] id_instr,
    output logic [ADDR_W-1:0] id_pc,
    output logic [ADDR_W-1:0] id_pc_next
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    localparam int unsigned       PTR_W      = $clog2(FIFO_DEPTH);
    localparam int unsigned       CNT_W      = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE    = PTR_W'(1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t                state;
    logic                  req_en;
    logic [ADDR_W-1:0]     fetch_pc;
    logic [PTR_W-1:0]      head_ptr;
    logic [PTR_W-1:0]      alloc_ptr;
    logic [PTR_W-1:0]      fill_ptr;
    logic [CNT_W-1:0]      occupancy;
    logic [CNT_W-1:0]      pending;
    logic [CNT_W-1:0]      drop_cnt;
    logic [FIFO_DEPTH-1:0] filled;
    logic [ADDR_W-1:0]     slot_pc    [FIFO_DEPTH];
    logic [DATA_W-1:0]     slot_instr [FIFO_DEPTH];

    logic             accept;
    logic             pop;
    logic             rsp_drop;
    logic             rsp_fill;
    logic [CNT_W-1:0] drop_after_rsp;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] drop_on_redirect;

    // req_en holds off issue for the first cycle after reset.
    assign imem_req_valid = req_en && (state == ST_RUN) && (occupancy != DEPTH_CNT) && !redirect_valid;
    assign imem_req_addr  = fetch_pc;
    assign accept         = imem_req_valid && imem_req_ready;

    assign id_valid   = filled[head_ptr];
    assign pop        = id_valid && id_ready;
    assign id_instr   = id_valid ? slot_instr[head_ptr] : '0;
    assign id_pc      = id_valid ? slot_pc[head_ptr] : '0;
    assign id_pc_next = id_valid ? slot_pc[head_ptr] + PC_INC : '0;

    assign rsp_drop       = imem_rsp_valid && (drop_cnt != '0);
    assign rsp_fill       = imem_rsp_valid && (drop_cnt == '0) && (pending != '0);
    assign drop_after_rsp = rsp_drop ? drop_cnt - CNT_ONE : drop_cnt;

    // A response landing in the redirect cycle belongs to the oldest old request and is retired here.
    assign outstanding      = drop_cnt + pending;
    assign drop_on_redirect = (imem_rsp_valid && (outstanding != '0)) ? outstanding - CNT_ONE : outstanding;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            req_en    <= 1'b0;
            fetch_pc  <= RESET_PC;
            head_ptr  <= '0;
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            occupancy <= '0;
            pending   <= '0;
            drop_cnt  <= '0;
            filled    <= '0;
        end else begin
            req_en <= 1'b1;
            if (redirect_valid) begin
                fetch_pc  <= redirect_pc & ALIGN_MASK;
                head_ptr  <= '0;
                alloc_ptr <= '0;
                fill_ptr  <= '0;
                occupancy <= '0;
                pending   <= '0;
                filled    <= '0;
                drop_cnt  <= drop_on_redirect;
                state     <= (drop_on_redirect != '0) ? ST_DRAIN : ST_RUN;
            end else begin
                if (accept) begin
                    alloc_ptr <= alloc_ptr + PTR_ONE;
                    fetch_pc  <= fetch_pc + PC_INC;
                end
                if (rsp_fill) begin
                    filled[fill_ptr] <= 1'b1;
                    fill_ptr         <= fill_ptr + PTR_ONE;
                end
                if (pop) begin
                    filled[head_ptr] <= 1'b0;
                    head_ptr         <= head_ptr + PTR_ONE;
                end
                occupancy <= occupancy + CNT_W'(accept) - CNT_W'(pop);
                pending   <= pending + CNT_W'(accept) - CNT_W'(rsp_fill);
                drop_cnt  <= drop_after_rsp;
                if ((state == ST_DRAIN) && (drop_after_rsp == '0)) begin
                    state <= ST_RUN;
                end
            end
        end
    end

    // NOTE: slot payload has no reset; the filled bits alone decide whether a slot is visible.
    always_ff @(posedge clk) begin
        if (accept) begin
            slot_pc[alloc_ptr] <= fetch_pc;
        end
        if (rsp_fill) begin
            slot_instr[fill_ptr] <= imem_rsp_data;
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (pop) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (!id_valid && (state == ST_RUN)) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed self-checking bench for if_fetch_unit with an in-order, fixed-latency instruction memory model.
// Instruction words are the bitwise inverse of their address so every expected value is derivable by hand.
module tb_if_fetch_unit;

    logic        clk            = 1'b0;
    logic        rst_n          = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = '0;
    logic        id_valid;
    logic        id_ready       = 1'b0;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_next;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    if_fetch_unit #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .RESET_PC  (32'h0),
        .PC_INC    (32'd4),
        .FIFO_DEPTH(4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .id_valid      (id_valid),
        .id_ready      (id_ready),
        .id_instr      (id_instr),
        .id_pc         (id_pc),
        .id_pc_next    (id_pc_next)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    // Memory model: responses in request order, each presented so it is sampled mem_lat edges after accept.
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_req_t;

    mem_req_t mem_q[$];
    int       edge_n  = 0;
    int       mem_lat = 1;

    always @(posedge clk) begin
        edge_n = edge_n + 1;
        if (!rst_n) begin
            mem_q.delete();
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= '0;
        end else begin
            if (imem_rsp_valid) begin
                void'(mem_q.pop_front());
            end
            if (imem_req_valid && imem_req_ready) begin
                mem_req_t r;
                r.addr = imem_req_addr;
                r.due  = edge_n + mem_lat;
                mem_q.push_back(r);
            end
            if ((mem_q.size() != 0) && (mem_q[0].due <= edge_n + 1)) begin
                imem_rsp_valid <= 1'b1;
                imem_rsp_data  <= ~mem_q[0].addr;
            end else begin
                imem_rsp_valid <= 1'b0;
                imem_rsp_data  <= '0;
            end
        end
    end

    // Transaction monitor: accepted request addresses and ID pops.
    logic [31:0] acc_q[$];
    logic [31:0] pop_pc_q[$];
    logic [31:0] pop_instr_q[$];
    logic [31:0] pop_next_q[$];

    always @(posedge clk) begin
        if (rst_n) begin
            if (imem_req_valid && imem_req_ready) acc_q.push_back(imem_req_addr);
            if (id_valid && id_ready) begin
                pop_pc_q.push_back(id_pc);
                pop_instr_q.push_back(id_instr);
                pop_next_q.push_back(id_pc_next);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s observed=%08h expected=%08h", tag, observed, expected);
        end
    endtask

    task automatic do_reset(input int lat, input logic req_rdy, input logic idr);
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        mem_lat        = lat;
        imem_req_ready = req_rdy;
        id_ready       = idr;
        repeat (2) @(negedge clk);
        check("rst imem_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("rst id_valid",       {31'd0, id_valid},       32'd0);
        check("rst id_instr",       id_instr,                32'd0);
        check("rst id_pc",          id_pc,                   32'd0);
        check("rst id_pc_next",     id_pc_next,              32'd0);
        acc_q.delete();
        pop_pc_q.delete();
        pop_instr_q.delete();
        pop_next_q.delete();
        rst_n = 1'b1;
    endtask

    task automatic wait_id_valid(input string tag, input int max_cyc);
        int k = 0;
        while ((id_valid !== 1'b1) && (k < max_cyc)) begin
            @(negedge clk);
            k++;
        end
        check(tag, {31'd0, id_valid}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: sequential fetch, 1-cycle memory, ID always ready
        do_reset(1, 1'b1, 1'b1);
        wait_id_valid("t1 first id_valid", 10);
        check("t1 head id_pc",      id_pc,      32'h0000_0000);
        check("t1 head id_instr",   id_instr,   32'hFFFF_FFFF);
        check("t1 head id_pc_next", id_pc_next, 32'h0000_0004);
        repeat (6) @(negedge clk);
        check("t1 req addr[1]",    acc_q[1],       32'h0000_0004);
        check("t1 req addr[2]",    acc_q[2],       32'h0000_0008);
        check("t1 pop pc[1]",      pop_pc_q[1],    32'h0000_0004);
        check("t1 pop pc[2]",      pop_pc_q[2],    32'h0000_0008);
        check("t1 pop instr[2]",   pop_instr_q[2], 32'hFFFF_FFF7);
        check("t1 pop pc_next[2]", pop_next_q[2],  32'h0000_000C);

        // 2: ID back-pressure fills the buffer, then drains in order
        do_reset(1, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        check("t2 accepted count",  acc_q.size(),            32'd4);
        check("t2 last addr",       acc_q[3],                32'h0000_000C);
        check("t2 full req_valid",  {31'd0, imem_req_valid}, 32'd0);
        check("t2 full head pc",    id_pc,                   32'h0000_0000);
        id_ready = 1'b1;
        repeat (8) @(negedge clk);
        check("t2 pop pc[0]",       pop_pc_q[0],    32'h0000_0000);
        check("t2 pop pc[3]",       pop_pc_q[3],    32'h0000_000C);
        check("t2 pop instr[3]",    pop_instr_q[3], 32'hFFFF_FFF3);
        check("t2 resume addr",     acc_q[4],       32'h0000_0010);

        // 3: redirect with two requests outstanding on a 3-cycle memory
        do_reset(3, 1'b0, 1'b1);
        @(negedge clk);
        check("t3 req_valid before", {31'd0, imem_req_valid}, 32'd1);
        imem_req_ready = 1'b1;
        repeat (2) @(negedge clk);
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        #1;
        check("t3 no req in redirect cycle", {31'd0, imem_req_valid}, 32'd0);
        @(negedge clk);
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        check("t3 id_valid after redirect", {31'd0, id_valid},       32'd0);
        check("t3 drain req_valid a",       {31'd0, imem_req_valid}, 32'd0);
        @(negedge clk);
        check("t3 drain req_valid b",       {31'd0, imem_req_valid}, 32'd0);
        @(negedge clk);
        check("t3 resume req_valid",        {31'd0, imem_req_valid}, 32'd1);
        check("t3 resume req_addr",         imem_req_addr,           32'h0000_0100);
        repeat (6) @(negedge clk);
        check("t3 third accepted addr",     acc_q[2],       32'h0000_0100);
        check("t3 first pop pc",            pop_pc_q[0],    32'h0000_0100);
        check("t3 first pop instr",         pop_instr_q[0], 32'hFFFF_FEFF);

        // 4: redirect coinciding with a response and an ID pop
        do_reset(1, 1'b1, 1'b1);
        repeat (5) @(negedge clk);
        check("t4 head before redirect",   id_pc,                   32'h0000_0008);
        check("t4 rsp coincident",         {31'd0, imem_rsp_valid}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        @(negedge clk);
        redirect_valid = 1'b0;
        check("t4 id_valid after redirect", {31'd0, id_valid}, 32'd0);
        repeat (6) @(negedge clk);
        check("t4 popped pc in redirect",   pop_pc_q[2],    32'h0000_0008);
        check("t4 pop after redirect",      pop_pc_q[3],    32'h0000_0200);
        check("t4 instr after redirect",    pop_instr_q[3], 32'hFFFF_FDFF);
        check("t4 first new req addr",      acc_q[4],       32'h0000_0200);

        // 5: PC wrap at the top of the address space
        do_reset(1, 1'b1, 1'b0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        @(negedge clk);
        redirect_valid = 1'b0;
        wait_id_valid("t5 id_valid", 10);
        check("t5 head pc",        id_pc,      32'hFFFF_FFFC);
        check("t5 head pc_next",   id_pc_next, 32'h0000_0000);
        check("t5 head instr",     id_instr,   32'h0000_0003);
        check("t5 req addr[0]",    acc_q[0],   32'hFFFF_FFFC);
        check("t5 wrapped addr",   acc_q[1],   32'h0000_0000);
        id_ready = 1'b1;
        @(negedge clk);
        check("t5 next head pc",      id_pc,      32'h0000_0000);
        check("t5 next head pc_next", id_pc_next, 32'h0000_0004);

`ifdef IF_PERF_CNT_EN
        // 6: performance counters
        do_reset(1, 1'b1, 1'b1);
        repeat (8) @(negedge clk);
        id_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("t6 perf_fetch_cnt", perf_fetch_cnt, 32'd5);
        check("t6 perf_stall_cnt", perf_stall_cnt, 32'd3);
        rst_n = 1'b0;
        @(negedge clk);
        check("t6 perf_fetch_cnt rst", perf_fetch_cnt, 32'd0);
        check("t6 perf_stall_cnt rst", perf_stall_cnt, 32'd0);
        rst_n = 1'b1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
